// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: the operation encoding forwarded to the
// single registered ALU.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, response buffers and ALU connections.
// The slave modport is the arbiter; master is the requester/ALU side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    op_t  [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ-1:0][31:0]  req_src1;
    logic [NUM_REQ-1:0][31:0]  req_src2;

    op_t                       alu_op;
    logic signed [31:0]        alu_src1;
    logic signed [31:0]        alu_src2;
    logic signed [31:0]        alu_res;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [NUM_REQ-1:0][31:0]  rsp_res;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready, alu_res,
        input  req_ready, alu_op, alu_src1, alu_src2, rsp_valid, rsp_res
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready, alu_res,
        output req_ready, alu_op, alu_src1, alu_src2, rsp_valid, rsp_res
    );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between NUM_REQ requesters, with
// one-cycle in-flight tracking and a one-entry response buffer per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t               rr_ptr_reg;
    ptr_t               rr_ptr_next;
    logic               inflight_valid_reg;
    ptr_t               inflight_id_reg;
    logic               rsp_valid_reg [NUM_REQ];
    logic [31:0]        rsp_res_reg   [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] capture;
    logic               grant_valid;
    ptr_t               grant_id;
    ptr_t               cand;

    function automatic ptr_t wrap_add(input ptr_t base, input int off);
        int sum;
        sum = int'(base) + off;
        return ptr_t'(sum % NUM_REQ);
    endfunction

    // A port may issue only if it has nothing in flight and its buffer will be
    // free by the time the result lands, so capture never collides with drain.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign capture[gi]  = inflight_valid_reg && (inflight_id_reg == ptr_t'(gi));
            assign eligible[gi] = bus.req_valid[gi] && !capture[gi] &&
                                  (!rsp_valid_reg[gi] || bus.rsp_ready[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_res_reg[gi]   <= '0;
                end else if (capture[gi]) begin
                    rsp_valid_reg[gi] <= 1'b1;
                    rsp_res_reg[gi]   <= bus.alu_res;
                end else if (bus.rsp_ready[gi]) begin
                    rsp_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr_reg, k);
            if (!grant_valid && !rst && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_next = grant_valid ? wrap_add(grant_id, 1) : rr_ptr_reg;
    end

    // Idle cycles still feed the ALU a harmless ADD 0,0; its result is dropped.
    always_comb begin
        bus.req_ready = '0;
        bus.alu_op    = OP_ADD;
        bus.alu_src1  = '0;
        bus.alu_src2  = '0;
        if (grant_valid) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.alu_op              = bus.req_op[grant_id];
            bus.alu_src1            = bus.req_src1[grant_id];
            bus.alu_src2            = bus.req_src2[grant_id];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = rsp_valid_reg[i];
            bus.rsp_res[i]   = rsp_res_reg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg         <= '0;
            inflight_valid_reg <= 1'b0;
            inflight_id_reg    <= '0;
        end else begin
            rr_ptr_reg         <= rr_ptr_next;
            inflight_valid_reg <= grant_valid;
            inflight_id_reg    <= grant_id;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a registered ALU model, a reference arbitration model
// and per-port result queues checked every cycle, plus directed scenarios.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] alu_f(input op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'b0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // External ALU: one-cycle registered result.
    always @(posedge clk) bus.alu_res <= alu_f(bus.alu_op, bus.alu_src1, bus.alu_src2);

    logic [N-1:0] drv_valid, drv_rdy, keep;
    logic         drv_rst;
    op_t          drv_op [N];
    logic [31:0]  drv_s1 [N];
    logic [31:0]  drv_s2 [N];

    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;

    int           m_ptr;
    logic         m_inf_v;
    int           m_inf_id;
    logic [N-1:0] exp_valid;
    logic [31:0]  exp_res [N];
    logic [31:0]  exp_q [N][$];

    logic [N-1:0] seen_ready, seen_rsp_valid;
    logic [31:0]  seen_res [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    endtask

    task automatic set_req(input int i, input op_t op, input logic [31:0] a, input logic [31:0] b);
        drv_op[i] = op;
        drv_s1[i] = a;
        drv_s2[i] = b;
    endtask

    task automatic apply_inputs();
        rst           = drv_rst;
        bus.req_valid = drv_valid;
        bus.rsp_ready = drv_rdy;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i]   = drv_op[i];
            bus.req_src1[i] = drv_s1[i];
            bus.req_src2[i] = drv_s2[i];
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, compare to the model, advance it.
    task automatic step();
        logic [N-1:0] want_ready;
        logic         gv;
        int           g;
        @(negedge clk);
        apply_inputs();
        #1;
        gv = 1'b0;
        g  = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!gv && !drv_rst && drv_valid[i] && !(m_inf_v && m_inf_id == i) &&
                (!exp_valid[i] || drv_rdy[i])) begin
                gv = 1'b1;
                g  = i;
            end
        end
        want_ready = '0;
        if (gv) want_ready[g] = 1'b1;

        seen_ready     = bus.req_ready;
        seen_rsp_valid = bus.rsp_valid;
        for (int i = 0; i < N; i++) seen_res[i] = bus.rsp_res[i];

        check_eq("req_ready", 32'(seen_ready), 32'(want_ready));
        check_eq("alu_op", 32'(bus.alu_op), gv ? 32'(drv_op[g]) : 32'(OP_ADD));
        check_eq("alu_src1", bus.alu_src1, gv ? drv_s1[g] : 32'h0);
        check_eq("alu_src2", bus.alu_src2, gv ? drv_s2[g] : 32'h0);
        check_eq("rsp_valid", 32'(seen_rsp_valid), 32'(exp_valid));
        for (int i = 0; i < N; i++) check_eq($sformatf("rsp_res[%0d]", i), seen_res[i], exp_res[i]);

        if (gv) $display("[%0d] grant port %0d %s %0d,%0d", cyc, g, drv_op[g].name(),
                         $signed(drv_s1[g]), $signed(drv_s2[g]));

        if (drv_rst) begin
            m_ptr     = 0;
            m_inf_v   = 1'b0;
            m_inf_id  = 0;
            exp_valid = '0;
            for (int i = 0; i < N; i++) begin
                exp_res[i] = 32'h0;
                exp_q[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_inf_v && m_inf_id == i) begin
                    exp_res[i]   = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 32'h0;
                    exp_valid[i] = 1'b1;
                end else if (drv_rdy[i]) begin
                    exp_valid[i] = 1'b0;
                end
            end
            if (gv) begin
                exp_q[g].push_back(alu_f(drv_op[g], drv_s1[g], drv_s2[g]));
                m_ptr = (g + 1) % N;
            end
            m_inf_v  = gv;
            m_inf_id = g;
        end

        for (int i = 0; i < N; i++) if (seen_ready[i] && !keep[i]) drv_valid[i] = 1'b0;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        drv_rst = 1'b1;
        repeat (n) step();
        drv_rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        drv_rst   = 1'b1;
        drv_valid = '1;
        drv_rdy   = '1;
        keep      = '0;
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, 32'd5, 32'd7);
        m_ptr     = 0;
        m_inf_v   = 1'b0;
        m_inf_id  = 0;
        exp_valid = '0;
        for (int i = 0; i < N; i++) exp_res[i] = 32'h0;
        apply_inputs();

        // Reset held with everyone requesting.
        repeat (2) begin
            step();
            check_eq("rst_ready", 32'(seen_ready), 32'h0);
            check_eq("rst_rsp_valid", 32'(seen_rsp_valid), 32'h0);
            check_eq("rst_rsp_res0", seen_res[0], 32'h0);
        end
        drv_rst = 1'b0;
        step();
        check_eq("rst_first_grant", 32'(seen_ready), 32'h1);
        drv_valid = '0;
        repeat (4) step();

        // Single operation on port 0.
        do_reset(1);
        set_req(0, OP_ADD, 32'd5, 32'd7);
        drv_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) check_eq("single_accept", 32'(seen_ready), 32'h1);
            if (k == 1) check_eq("single_early", 32'(seen_rsp_valid), 32'h0);
            if (k == 2) begin
                check_eq("single_valid", 32'(seen_rsp_valid), 32'h1);
                check_eq("single_res", seen_res[0], 32'd12);
            end
        end

        // Contention: both ports always requesting.
        do_reset(1);
        keep = '1;
        set_req(0, OP_SUB, 32'd10, 32'd3);
        set_req(1, OP_SLL, 32'd1, 32'd4);
        drv_valid = '1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("cont_grant", 32'(seen_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k >= 2) begin
                check_eq("cont_rsp_valid", 32'(seen_rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
                if (k % 2 == 0) check_eq("cont_res0", seen_res[0], 32'd7);
                else            check_eq("cont_res1", seen_res[1], 32'd16);
            end
        end

        // Back-to-back on a single port.
        do_reset(1);
        keep = 2'b01;
        set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd0);
        drv_valid = 2'b01;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("b2b_grant", 32'(seen_ready[0]), 32'(k % 2 == 0));
            check_eq("b2b_valid", 32'(seen_rsp_valid[0]), 32'(k >= 2 && k % 2 == 0));
            if (k >= 2 && k % 2 == 0) check_eq("b2b_res", seen_res[0], 32'd1);
        end

        // Backpressure on port 1.
        do_reset(1);
        keep = '1;
        set_req(0, OP_ADD, 32'd2, 32'd3);
        set_req(1, OP_SUB, 32'd10, 32'd3);
        drv_valid = '1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) drv_rdy[1] = 1'b0;
            if (k == 8) drv_rdy[1] = 1'b1;
            step();
            if (k == 1) begin
                check_eq("bp_first_grant", 32'(seen_ready), 32'h2);
                set_req(1, OP_SUB, 32'd100, 32'd1);
            end
            if (k >= 3 && k < 8) begin
                check_eq("bp_hold_valid", 32'(seen_rsp_valid[1]), 32'h1);
                check_eq("bp_hold_res", seen_res[1], 32'd7);
                check_eq("bp_no_grant", 32'(seen_ready[1]), 32'h0);
            end
            if (k == 8) check_eq("bp_regrant", 32'(seen_ready[1]), 32'h1);
            if (k == 10) begin
                check_eq("bp_new_valid", 32'(seen_rsp_valid[1]), 32'h1);
                check_eq("bp_new_res", seen_res[1], 32'd99);
            end
        end

        // Reset while an operation is in flight.
        do_reset(1);
        keep    = '0;
        drv_rdy = '1;
        set_req(0, OP_ADD, 32'd5, 32'd7);
        drv_valid = 2'b01;
        step();
        check_eq("mid_accept", 32'(seen_ready), 32'h1);
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("mid_no_rsp", 32'(seen_rsp_valid[0]), 32'h0);
        end
        set_req(1, OP_OR, 32'd1, 32'd2);
        drv_valid = '1;
        step();
        check_eq("mid_next_grant", 32'(seen_ready), 32'h1);
        repeat (3) step();

        // Random traffic, backpressure and occasional resets.
        keep = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!drv_valid[i] && $urandom_range(0, 1) == 1) begin
                    drv_valid[i] = 1'b1;
                    set_req(i, op_t'($urandom_range(0, 9)), $urandom, $urandom);
                end
            end
            drv_rdy = N'($urandom);
            drv_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        drv_rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
